uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with a built-in transmit FIFO. Data width, parity and stop-bit count are configurable.
//  Host logic pushes words with a valid/ready handshake. The block serialises them LSB-first onto o_txSerial.
//  Queued frames go out back-to-back with no idle gap. Drop-in successor to the single-byte TX for LCD/debug links.
// PARAMETERS
//  CLOCK_SPEED     1000000   input clock frequency, Hz
//  BAUD_RATE       9600      line rate, bit/s
//  CLOCKS_PER_BIT  CLOCK_SPEED/BAUD_RATE  cycles per line bit; must be >= 2 (elaboration error otherwise)
//  DATA_BITS       8         data bits per frame, 5..9
//  PARITY          0         0 = none, 1 = even, 2 = odd
//  STOP_BITS       1         1 or 2
//  FIFO_DEPTH      4         entries; power of 2, >= 2
// PORTS
//  i_clock        in   1                       system clock, rising edge
//  i_reset        in   1                       asynchronous, active-high reset
//  i_txValid      in   1                       push request
//  i_txData       in   DATA_BITS               word to queue
//  o_txReady      out  1                       FIFO not full (push accepted when valid & ready)
//  o_txSerial     out  1                       UART line, idle high, registered
//  o_txBusy       out  1                       frame on the line
//  o_txDone       out  1                       1-cycle pulse per completed frame
//  o_overflow     out  1                       1-cycle pulse: push attempted while full, word dropped
//  o_fifoCount    out  $clog2(FIFO_DEPTH)+1    entries queued, excluding the frame in flight
// BEHAVIOUR
//  Reset: async; o_txSerial=1, o_txBusy=0, o_txDone=0, o_overflow=0, o_fifoCount=0, FIFO emptied, FSM=IDLE.
//    o_txReady=1 after reset. A reset mid-frame aborts the frame; the line goes high at once; no o_txDone pulse.
//  FIFO:
//    o_txReady = !full, from registered count.
//    A push while full is dropped and o_overflow pulses, even if a pop occurs in the same cycle.
//    Simultaneous push and pop with count in 1..DEPTH-1: count unchanged, ordering preserved.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//    IDLE: line=1, busy=0. If FIFO not empty: pop at this edge, load the shift register, latch the parity bit.
//      Then go to START; line=0 and busy=1 from the same edge.
//      Latency: a word pushed at edge k into an empty FIFO with FSM idle -> start bit begins at edge k+1.
//    START: held CLOCKS_PER_BIT cycles, then DATA.
//    DATA: DATA_BITS bits, LSB first, each CLOCKS_PER_BIT cycles.
//      Then go to PARITY if PARITY != 0, else STOP.
//    PARITY: even -> XOR of data bits; odd -> inverted XOR; CLOCKS_PER_BIT cycles.
//    STOP: line=1 for STOP_BITS*CLOCKS_PER_BIT cycles. On the last cycle's edge o_txDone pulses for 1 cycle.
//      If FIFO not empty: pop and enter START directly (zero gap, busy stays 1). Else IDLE, busy=0.
//  Frame length exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLOCKS_PER_BIT cycles; no off-by-one.
//  Counter widths: bit timer $clog2(CLOCKS_PER_BIT); bit index $clog2(DATA_BITS+1). Timer reloads to 0 each bit.
//  The word in flight is held in a local shift register; the FIFO slot is freed at the pop.
// STRUCTURE
//  uart_pkg: FSM state encoding, PARITY_NONE/EVEN/ODD constants, frame-length function.
//  Sub-module sync_fifo (DATA_WIDTH, DEPTH): push/pop, full/empty, count; no first-word fall-through needed.
//  Top: FSM + bit timer + shift register + parity latch; all outputs registered except o_txReady.
// TESTING (CLOCKS_PER_BIT=4 unless noted)
//  8N1, push 0xA5 -> start at k+1; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop 4; done pulses once; 40 cycles total.
//  8E1 0x07 -> parity bit 1; 8O1 0x00 -> parity 1; 8O1 0x01 -> parity 0; frame 44 cycles.
//  DEPTH=4, idle-blocked fill: push 5 words in 5 cycles -> first pops at once, 4 queue.
//    Then a 6th push while full -> overflow pulse, word lost. Remaining frames back-to-back, no high gap between them.
//    5 done pulses; busy held high throughout.
//  7N2, push 0x7F -> 7 data bits then stop high for 8 cycles; frame 40 cycles.
//  Reset asserted mid-DATA -> line 1 immediately, count 0, no done pulse.
//    After release, a push of 0x3C -> clean full frame.
//  Simultaneous push and pop at count=2 -> count stays 2; the output data order matches the push order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding, parity modes
// and small frame helpers used by the datapath.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_EVEN   = 1;
  localparam int PARITY_ODD    = 2;
  localparam int MAX_DATA_BITS = 9;

  function automatic int frame_cycles(input int data_bits, input int parity,
                                      input int stop_bits, input int clocks_per_bit);
    return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * clocks_per_bit;
  endfunction

  // Data is zero-extended by the caller, so unused upper bits do not disturb the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int parity);
    return (^data) ^ (parity == PARITY_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered occupancy count; pop_data presents the head entry
// whenever the FIFO is not empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok;
  logic                  pop_ok;

  // A push while full is refused even if a pop frees a slot in the same cycle.
  assign full     = (count_q == COUNT_FULL);
  assign empty    = (count_q == {CW{1'b0}});
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Storage, pointer and occupancy update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; queued words leave LSB first, back-to-back,
// with optional parity and one or two stop bits.
module uart_tx_fifo #(
  parameter int CLOCK_SPEED    = 1000000,
  parameter int BAUD_RATE      = 9600,
  parameter int CLOCKS_PER_BIT = CLOCK_SPEED / BAUD_RATE,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_txValid,
  input  logic [DATA_BITS-1:0]          i_txData,
  output logic                          o_txReady,
  output logic                          o_txSerial,
  output logic                          o_txBusy,
  output logic                          o_txDone,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifoCount
);

  import uart_pkg::*;

  if (CLOCKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLOCKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
  end

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST  = IW'(STOP_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [IW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   serial_q, serial_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;

  logic                       bit_end;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [DATA_BITS-1:0]       fifo_data;
  logic [MAX_DATA_BITS-1:0]   fifo_ext;

  sync_fifo #(
    .DATA_WIDTH (DATA_BITS),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clock),
    .rst       (i_reset),
    .push      (i_txValid),
    .push_data (i_txData),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_fifoCount)
  );

  assign bit_end    = (timer_q == TIMER_LAST);
  assign o_txReady  = !fifo_full;
  assign o_txSerial = serial_q;
  assign o_txBusy   = busy_q;
  assign o_txDone   = done_q;
  assign o_overflow = ovf_q;

  // Zero-extend the head word so the shared parity helper sees a fixed width.
  always_comb begin
    fifo_ext                = {MAX_DATA_BITS{1'b0}};
    fifo_ext[DATA_BITS-1:0] = fifo_data;
  end

  // State register: FSM, bit timing, shift register and registered outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= {TW{1'b0}};
      bit_idx_q <= {IW{1'b0}};
      shift_q   <= {DATA_BITS{1'b0}};
      par_q     <= 1'b0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state logic; a word is popped from IDLE or straight out of the last stop bit.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_START;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end) begin
          timer_d = {TW{1'b0}};
          state_d = ST_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          timer_d = {TW{1'b0}};
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = {IW{1'b0}};
            state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          timer_d   = {TW{1'b0}};
          bit_idx_d = {IW{1'b0}};
          state_d   = ST_STOP;
        end else begin
          timer_d   = timer_q + TW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          timer_d = {TW{1'b0}};
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = {IW{1'b0}};
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              state_d  = ST_START;
            end else begin
              state_d  = ST_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        timer_d   = {TW{1'b0}};
        bit_idx_d = {IW{1'b0}};
      end
    endcase
    if (fifo_pop) begin
      shift_d = fifo_data;
      par_d   = parity_bit(fifo_ext, PARITY);
    end else begin
      par_d   = par_q;
    end
  end

  // Output logic, driven from the next state so the line changes on the transition edge.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && bit_end && (bit_idx_q == STOP_LAST);
    ovf_d  = i_txValid && fifo_full;
    case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = shift_d[0];
      ST_PARITY: serial_d = par_d;
      default:   serial_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances (8N1, 8E1, 8O1, 7N2) at 4 clocks per
// bit, frame vectors from a table plus hand-written FIFO, ordering and reset sequences.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       valid  [4];
  logic [8:0] din    [4];
  logic       ready  [4];
  logic       serial [4];
  logic       busy   [4];
  logic       done   [4];
  logic       ovf    [4];
  logic [2:0] cnt    [4];

  int checks;
  int errors;

  typedef struct {
    int         sel;
    logic [8:0] data;
    logic [11:0] bits;   // expected line bits in send order, bit 0 = start bit
    int         nbits;
    int         cycles;
  } vec_t;

  vec_t vecs [7];

  uart_tx_fifo #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .i_clock(clk), .i_reset(rst), .i_txValid(valid[0]), .i_txData(din[0][7:0]),
    .o_txReady(ready[0]), .o_txSerial(serial[0]), .o_txBusy(busy[0]), .o_txDone(done[0]),
    .o_overflow(ovf[0]), .o_fifoCount(cnt[0]));
  uart_tx_fifo #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .i_clock(clk), .i_reset(rst), .i_txValid(valid[1]), .i_txData(din[1][7:0]),
    .o_txReady(ready[1]), .o_txSerial(serial[1]), .o_txBusy(busy[1]), .o_txDone(done[1]),
    .o_overflow(ovf[1]), .o_fifoCount(cnt[1]));
  uart_tx_fifo #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .i_clock(clk), .i_reset(rst), .i_txValid(valid[2]), .i_txData(din[2][7:0]),
    .o_txReady(ready[2]), .o_txSerial(serial[2]), .o_txBusy(busy[2]), .o_txDone(done[2]),
    .o_overflow(ovf[2]), .o_fifoCount(cnt[2]));
  uart_tx_fifo #(.CLOCKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .i_clock(clk), .i_reset(rst), .i_txValid(valid[3]), .i_txData(din[3][6:0]),
    .o_txReady(ready[3]), .o_txSerial(serial[3]), .o_txBusy(busy[3]), .o_txDone(done[3]),
    .o_overflow(ovf[3]), .o_fifoCount(cnt[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Expected 8N1 line level for word w at cycle fc of its 40-cycle frame.
  function automatic logic exp_8n1(input logic [7:0] w, input int fc);
    int bi;
    bi = fc / 4;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return w[bi-1];
    return 1'b1;
  endfunction

  task automatic run_frame(input vec_t v);
    int busy_cnt;
    int done_cnt;
    @(negedge clk);
    valid[v.sel] = 1'b1;
    din[v.sel]   = v.data;
    @(negedge clk);
    valid[v.sel] = 1'b0;
    chk("pre_start_line", 32'(serial[v.sel]), 32'd1);
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < v.cycles; c++) begin
      @(negedge clk);
      chk($sformatf("line_sel%0d_d%0h_c%0d", v.sel, v.data, c), 32'(serial[v.sel]), 32'(v.bits[c/4]));
      busy_cnt += int'(busy[v.sel]);
      done_cnt += int'(done[v.sel]);
    end
    @(negedge clk);
    chk("frame_done_pulse", 32'(done[v.sel]), 32'd1);
    chk("frame_busy_after", 32'(busy[v.sel]), 32'd0);
    done_cnt += int'(done[v.sel]);
    @(negedge clk);
    done_cnt += int'(done[v.sel]);
    chk("frame_busy_cycles", 32'(busy_cnt), 32'(v.cycles));
    chk("frame_done_count", 32'(done_cnt), 32'd1);
  endtask

  // Burst on the 8N1 instance: early pushes on consecutive edges, optional push into a
  // full FIFO, and a push landing on the edge that ends the first frame (edge 42).
  task automatic run_seq(input string nm, input logic [7:0] pw [8], input int n_early,
                         input bit ovf_early, input logic [7:0] late_w, input bit late_ovf,
                         input int cnt42, input logic [7:0] fw [8], input int n_frames);
    int done_cnt;
    int ovf_cnt;
    int t_end;
    done_cnt = 0;
    ovf_cnt  = 0;
    t_end    = 2 + 40 * n_frames;
    @(negedge clk);
    valid[0] = 1'b1;
    din[0]   = {1'b0, pw[0]};
    for (int t = 1; t <= t_end; t++) begin
      @(negedge clk);
      done_cnt += int'(done[0]);
      ovf_cnt  += int'(ovf[0]);
      if (t >= 2 && t < t_end) begin
        chk($sformatf("%s_line_c%0d", nm, t - 2), 32'(serial[0]),
            32'(exp_8n1(fw[(t-2)/40], (t-2) % 40)));
        chk($sformatf("%s_busy_c%0d", nm, t - 2), 32'(busy[0]), 32'd1);
      end
      if (t == 1) begin
        chk({nm, "_t1_line"}, 32'(serial[0]), 32'd1);
        chk({nm, "_t1_count"}, 32'(cnt[0]), 32'd1);
      end
      if (t == 2) chk({nm, "_t2_count"}, 32'(cnt[0]), 32'd1);
      if (t == n_early) begin
        chk({nm, "_fill_count"}, 32'(cnt[0]), 32'(n_early - 1));
        chk({nm, "_fill_ready"}, 32'(ready[0]), (n_early - 1 < 4) ? 32'd1 : 32'd0);
      end
      if (ovf_early && t == n_early + 1) begin
        chk({nm, "_ovf_full"}, 32'(ovf[0]), 32'd1);
        chk({nm, "_ovf_count"}, 32'(cnt[0]), 32'd4);
      end
      if (t == 42) begin
        chk({nm, "_t42_ovf"}, 32'(ovf[0]), 32'(late_ovf));
        chk({nm, "_t42_count"}, 32'(cnt[0]), 32'(cnt42));
      end
      if (t == t_end) begin
        chk({nm, "_end_done"}, 32'(done[0]), 32'd1);
        chk({nm, "_end_busy"}, 32'(busy[0]), 32'd0);
      end
      if (t < n_early) begin
        valid[0] = 1'b1;
        din[0]   = {1'b0, pw[t]};
      end else if (t == n_early && ovf_early) begin
        valid[0] = 1'b1;
        din[0]   = 9'h0EE;
      end else if (t == 41) begin
        valid[0] = 1'b1;
        din[0]   = {1'b0, late_w};
      end else begin
        valid[0] = 1'b0;
      end
    end
    @(negedge clk);
    done_cnt += int'(done[0]);
    chk({nm, "_done_total"}, 32'(done_cnt), 32'(n_frames));
    chk({nm, "_ovf_total"}, 32'(ovf_cnt), 32'(int'(ovf_early) + int'(late_ovf)));
    chk({nm, "_final_count"}, 32'(cnt[0]), 32'd0);
  endtask

  initial begin
    logic [7:0] pw [8];
    logic [7:0] fw [8];
    int done_cnt;
    int line_low;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      din[i]   = 9'h000;
    end

    vecs[0] = '{0, 9'h0A5, 12'h34A, 10, 40};
    vecs[1] = '{0, 9'h000, 12'h200, 10, 40};
    vecs[2] = '{1, 9'h007, 12'h60E, 11, 44};
    vecs[3] = '{1, 9'h003, 12'h406, 11, 44};
    vecs[4] = '{2, 9'h000, 12'h600, 11, 44};
    vecs[5] = '{2, 9'h001, 12'h402, 11, 44};
    vecs[6] = '{3, 9'h07F, 12'h3FE, 10, 40};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_line", 32'(serial[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_ovf", 32'(ovf[0]), 32'd0);
    chk("rst_count", 32'(cnt[0]), 32'd0);
    chk("rst_ready", 32'(ready[0]), 32'd1);

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    pw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00};
    fw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00};
    run_seq("fill", pw, 5, 1'b1, 8'hEE, 1'b1, 3, fw, 5);

    pw = '{8'hA0, 8'h5B, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fw = '{8'hA0, 8'h5B, 8'hC3, 8'h96, 8'h00, 8'h00, 8'h00, 8'h00};
    run_seq("pushpop", pw, 3, 1'b0, 8'h96, 1'b0, 2, fw, 4);

    // Reset in the middle of a data bit with one word still queued.
    @(negedge clk);
    valid[0] = 1'b1;
    din[0]   = 9'h0A5;
    @(negedge clk);
    din[0]   = 9'h0F0;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_data_line_low", 32'(serial[0]), 32'd0);
    chk("mid_data_count", 32'(cnt[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_line", 32'(serial[0]), 32'd1);
    chk("async_rst_count", 32'(cnt[0]), 32'd0);
    chk("async_rst_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    line_low = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      done_cnt += int'(done[0]);
      line_low += int'(!serial[0]);
    end
    chk("post_rst_done", 32'(done_cnt), 32'd0);
    chk("post_rst_line_low", 32'(line_low), 32'd0);
    run_frame('{0, 9'h03C, 12'h278, 10, 40});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
